// File: rtl/instr_sequencer.sv
// Program sequencer for the two-register processor: fetches 16-bit words from a
// synchronous ROM, issues each one with a single run pulse and waits for done.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] prog_end_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_data_i,
  output logic [15:0]       instr_o,
  output logic              run_o,
  input  logic              done_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [ADDR_W:0]   instr_count_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam int                 WDOG_W   = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0]  WDOG_MAX = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0]  WDOG_ONE = WDOG_W'(1);
  localparam logic [ADDR_W-1:0]  PC_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]    CNT_ONE  = (ADDR_W + 1)'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [15:0]       instr_q, instr_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              run_q, busy_q, halted_q;

  // Next-state logic; start is only accepted from IDLE or HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    instr_d = instr_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          pend_d  = prog_end_i;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        instr_d = mem_data_i;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a watchdog expiring in the same cycle
        if (done_i) begin
          cnt_d = cnt_q + CNT_ONE;
          if (pc_q == pend_q) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end else if (wdog_q == WDOG_MAX) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; flags are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      pend_q   <= '0;
      instr_q  <= 16'h0000;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      instr_q  <= instr_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      run_q    <= (state_d == S_ISSUE);
      busy_q   <= (state_d == S_FETCH) || (state_d == S_LOAD) ||
                  (state_d == S_ISSUE) || (state_d == S_WAIT);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign mem_addr_o    = pc_q;
  assign instr_o       = instr_q;
  assign run_o         = run_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign err_o         = err_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: sync ROM model plus a processor stub answering run
// with a chosen done latency; expectations come from a program-level timing model.
module tb_instr_sequencer;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk;
  logic              reset_i;
  logic              start_i;
  logic [ADDR_W-1:0] prog_end_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [15:0]       mem_data_i;
  logic [15:0]       instr_o;
  logic              run_o;
  logic              done_i;
  logic              busy_o;
  logic              halted_o;
  logic              err_o;
  logic [ADDR_W:0]   instr_count_o;

  logic [15:0] rom [DEPTH];
  int          lat [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    int pend;
    int lat;
    int to_idx;
    int exp_count;
    int exp_err;
    int exp_addr;
  } vec_t;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .prog_end_i    (prog_end_i),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .instr_o       (instr_o),
    .run_o         (run_o),
    .done_i        (done_i),
    .busy_o        (busy_o),
    .halted_o      (halted_o),
    .err_o         (err_o),
    .instr_count_o (instr_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data valid one cycle after the address.
  always_ff @(posedge clk) mem_data_i <= rom[mem_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one program from start; abort_cy > 0 raises reset in that cycle instead of finishing.
  task automatic run_prog(input int pend, input int abort_cy);
    int  rt[$];
    int  th, c, k, ri, w, ecount, eerr, eaddr;
    bit  active;
    c = 3; ecount = 0; eerr = 0; eaddr = 0; th = 0;
    for (int i = 0; i <= pend; i++) begin
      rt.push_back(c);
      eaddr = i;
      if (lat[i] > TIMEOUT) begin
        eerr = 1;
        th   = c + TIMEOUT + 1;
        break;
      end
      ecount++;
      if (i == pend) begin
        th = c + lat[i] + 1;
        break;
      end
      c = c + lat[i] + 3;
    end
    start_i    = 1'b1;
    prog_end_i = ADDR_W'(pend);
    k = 0; ri = -1; w = 0; active = 1'b0;
    for (int cy = 1; cy <= th; cy++) begin
      @(negedge clk);
      done_i     = 1'b0;
      start_i    = (cy < th) ? ($urandom_range(0, 7) == 0) : 1'b0;
      prog_end_i = ADDR_W'($urandom_range(0, DEPTH - 1));
      if (cy == 1) begin
        check("start_err_clr", err_o, 0);
        check("start_cnt_clr", instr_count_o, 0);
        check("start_addr", mem_addr_o, 0);
      end
      check("run", run_o, (k < rt.size() && rt[k] == cy));
      if (k < rt.size() && rt[k] == cy) k++;
      check("busy", busy_o, (cy < th));
      check("halted", halted_o, (cy == th));
      if (run_o) begin
        ri++;
        w = 0;
        active = (ri < DEPTH);
        if (active) begin
          check("instr_issue", instr_o, rom[ri]);
          check("addr_issue", mem_addr_o, ri);
        end
      end else if (active) begin
        w++;
        check("instr_hold", instr_o, rom[ri]);
        if (w == lat[ri]) begin
          done_i = 1'b1;
          active = 1'b0;
        end
      end
      if (cy == abort_cy) begin
        reset_i = 1'b1;
        done_i  = 1'b0;
        start_i = 1'b0;
        return;
      end
    end
    check("final_count", instr_count_o, ecount);
    check("final_err", err_o, eerr);
    check("final_addr", mem_addr_o, eaddr);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, mem_addr_o, 0);
    check({tag, "_instr"}, instr_o, 0);
    check({tag, "_run"}, run_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_halted"}, halted_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_cnt"}, instr_count_o, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{pend: 0,  lat: 1, to_idx: -1, exp_count: 1,  exp_err: 0, exp_addr: 0};
    vecs[1] = '{pend: 3,  lat: 3, to_idx: -1, exp_count: 4,  exp_err: 0, exp_addr: 3};
    vecs[2] = '{pend: 2,  lat: 1, to_idx: 0,  exp_count: 0,  exp_err: 1, exp_addr: 0};
    vecs[3] = '{pend: 5,  lat: 8, to_idx: -1, exp_count: 6,  exp_err: 0, exp_addr: 5};
    vecs[4] = '{pend: 6,  lat: 2, to_idx: 3,  exp_count: 3,  exp_err: 1, exp_addr: 3};
    vecs[5] = '{pend: 31, lat: 1, to_idx: -1, exp_count: 32, exp_err: 0, exp_addr: 31};
    vecs[6] = '{pend: 4,  lat: 7, to_idx: -1, exp_count: 5,  exp_err: 0, exp_addr: 4};

    for (int i = 0; i < DEPTH; i++) rom[i] = 16'($urandom_range(1, 65535));
    rom[0] = 16'h2005; rom[1] = 16'h3003; rom[2] = 16'h4001; rom[3] = 16'hE002;

    reset_i = 1'b1; start_i = 1'b0; done_i = 1'b0; prog_end_i = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_i = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_o, 0);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < DEPTH; i++) lat[i] = (i == vecs[v].to_idx) ? TIMEOUT + 1 : vecs[v].lat;
      run_prog(vecs[v].pend, 0);
      check("tbl_count", instr_count_o, vecs[v].exp_count);
      check("tbl_err", err_o, vecs[v].exp_err);
      check("tbl_addr", mem_addr_o, vecs[v].exp_addr);
      check("tbl_halted", halted_o, 1);
    end

    // HALT must be stable with no start.
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("halt_hold_addr", mem_addr_o, 4);
    check("halt_hold_run", run_o, 0);

    // Reset in the second WAIT cycle of the third add-like instruction.
    for (int i = 0; i < DEPTH; i++) lat[i] = 3;
    run_prog(3, 17);
    check("pre_rst_instr", instr_o, rom[2]);
    @(negedge clk);
    check_reset_vals("midrst");
    reset_i = 1'b0;
    run_prog(3, 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rom[i] = 16'($urandom_range(1, 65535));
        lat[i] = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT);
      end
      run_prog($urandom_range(0, DEPTH - 1), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
